// File: rtl/sr_latch_clocked.sv
// Bank of WIDTH independent clocked SR cells with NOR-latch output semantics.
// Each cell holds CLEAR/SET/INVALID; the forbidden S+R request parks the cell in INVALID.

module sr_latch_cell (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic reset,
   output logic q,
   output logic q_not,
   output logic invalid,
   output logic invalid_nxt
);

   typedef enum logic [1:0] {
      CLEAR   = 2'b00,
      SET     = 2'b01,
      INVALID = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= CLEAR;
      else     r_state <= w_state_nxt;
   end

   // 0,0 holds any state, so INVALID persists until an explicit set or clear
   always_comb begin
      w_state_nxt = r_state;
      case ({set, reset})
         2'b01:   w_state_nxt = CLEAR;
         2'b10:   w_state_nxt = SET;
         2'b11:   w_state_nxt = INVALID;
         default: w_state_nxt = r_state;
      endcase
   end

   assign q           = (r_state == SET);
   assign q_not       = (r_state == CLEAR);
   assign invalid     = (r_state == INVALID);
   assign invalid_nxt = (w_state_nxt == INVALID);

endmodule

module sr_latch_clocked #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] set,
   input  logic [WIDTH-1:0] reset,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_not,
   output logic [WIDTH-1:0] invalid,
   output logic             invalid_any
);

   logic [WIDTH-1:0] w_invalid_nxt;
   logic             r_invalid_any;

   sr_latch_cell u_cell [WIDTH-1:0] (
      .clk         (clk),
      .rst         (rst),
      .set         (set),
      .reset       (reset),
      .q           (q),
      .q_not       (q_not),
      .invalid     (invalid),
      .invalid_nxt (w_invalid_nxt)
   );

   // Registered from next-state so it updates on the same edge as the cells
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_invalid_any <= 1'b0;
      else     r_invalid_any <= |w_invalid_nxt;
   end

   assign invalid_any = r_invalid_any;

endmodule

// File: tb/tb_sr_latch_clocked.sv
// Self-checking bench for sr_latch_clocked: directed table on a 1-bit bank,
// multi-bit and randomized checks on a 4-bit bank against a bitwise model.

module tb_sr_latch_clocked;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s1 = 1'b0, r1 = 1'b0;
   logic       q1, qn1, inv1, any1;
   logic [3:0] s4 = '0, r4 = '0;
   logic [3:0] q4, qn4, inv4;
   logic       any4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sr_latch_clocked #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .set(s1), .reset(r1),
      .q(q1), .q_not(qn1), .invalid(inv1), .invalid_any(any1)
   );

   sr_latch_clocked #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .set(s4), .reset(r4),
      .q(q4), .q_not(qn4), .invalid(inv4), .invalid_any(any4)
   );

   typedef struct {
      logic s;
      logic r;
      logic q;
      logic qn;
      logic inv;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic eq, input logic eqn, input logic einv);
      chk({name, ".q"},     64'(q1),   64'(eq));
      chk({name, ".q_not"}, 64'(qn1),  64'(eqn));
      chk({name, ".inv"},   64'(inv1), 64'(einv));
      chk({name, ".any"},   64'(any1), 64'(einv));
   endtask

   // Model: a cell is SET when q=1, INVALID when inv=1, otherwise CLEAR
   logic [3:0] m_q, m_inv;

   task automatic model_step(input logic [3:0] s, input logic [3:0] r);
      logic [3:0] hold;
      hold  = ~s & ~r;
      m_inv = (s & r) | (m_inv & hold);
      m_q   = (s & ~r) | (m_q & hold);
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back('{s:0, r:0, q:0, qn:1, inv:0});
      tbl.push_back('{s:0, r:1, q:0, qn:1, inv:0});
      tbl.push_back('{s:1, r:0, q:1, qn:0, inv:0});
      tbl.push_back('{s:0, r:0, q:1, qn:0, inv:0});
      tbl.push_back('{s:0, r:0, q:1, qn:0, inv:0});
      tbl.push_back('{s:0, r:0, q:1, qn:0, inv:0});
      tbl.push_back('{s:1, r:1, q:0, qn:0, inv:1});
      tbl.push_back('{s:0, r:0, q:0, qn:0, inv:1});
      tbl.push_back('{s:0, r:0, q:0, qn:0, inv:1});
      tbl.push_back('{s:0, r:1, q:0, qn:1, inv:0});
      tbl.push_back('{s:1, r:0, q:1, qn:0, inv:0});
      tbl.push_back('{s:1, r:1, q:0, qn:0, inv:1});
      tbl.push_back('{s:1, r:0, q:1, qn:0, inv:0});

      // Reset asserted with set requested: cleared immediately and while held
      s1 = 1'b1; r1 = 1'b0;
      #1;
      chk1("rst_imm", 1'b0, 1'b1, 1'b0);
      chk("rst_imm.q4",  64'(q4),  64'h0);
      chk("rst_imm.qn4", 64'(qn4), 64'hf);
      @(posedge clk); #1;
      chk1("rst_held", 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0; s1 = 1'b0; r1 = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         s1 = tbl[i].s; r1 = tbl[i].r;
         @(posedge clk); #1;
         chk1($sformatf("tbl%0d", i), tbl[i].q, tbl[i].qn, tbl[i].inv);
      end

      // Mid-cycle input change must not reach outputs before the next edge
      s1 = 1'b0; r1 = 1'b1;
      #2;
      chk1("lat_before", 1'b1, 1'b0, 1'b0);
      s1 = 1'b1; r1 = 1'b1;
      #1;
      s1 = 1'b0; r1 = 1'b1;
      @(posedge clk); #1;
      chk1("lat_after", 1'b0, 1'b1, 1'b0);

      @(negedge clk);
      s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;
      @(posedge clk); #1;
      chk1("pre_async", 1'b1, 1'b0, 1'b0);
      chk("pre_async.q4", 64'(q4), 64'hf);

      // Asynchronous reset between edges, pending set requests ignored
      #2 rst = 1'b1;
      #1;
      chk1("async_rst", 1'b0, 1'b1, 1'b0);
      chk("async_rst.q4",  64'(q4),  64'h0);
      chk("async_rst.qn4", 64'(qn4), 64'hf);
      @(posedge clk); #1;
      chk("async_held.q4", 64'(q4), 64'h0);

      // Multi-bit: set wins on bit1, clear on bit2, forbidden on bit0, bit3 idle
      @(negedge clk);
      rst = 1'b0; s1 = 1'b0; r1 = 1'b0;
      s4 = 4'b0011; r4 = 4'b0101;
      m_q = '0; m_inv = '0;
      model_step(s4, r4);
      @(posedge clk); #1;
      chk("mb.q",     64'(q4),   64'b0010);
      chk("mb.q_not", 64'(qn4),  64'b1100);
      chk("mb.inv",   64'(inv4), 64'b0001);
      chk("mb.any",   64'(any4), 64'h1);
      chk("mb.model", 64'({m_q, m_inv}), 64'({4'b0010, 4'b0001}));

      // Randomized run against the bitwise model
      for (int c = 0; c < 1000; c++) begin
         logic [3:0] qn_exp;
         @(negedge clk);
         s4 = 4'($urandom);
         r4 = 4'($urandom);
         if (($urandom % 4) == 0) begin
            s4 = '0; r4 = '0;
         end
         model_step(s4, r4);
         @(posedge clk); #1;
         qn_exp = ~m_q & ~m_inv;
         chk($sformatf("rnd%0d.q", c),   64'(q4),   64'(m_q));
         chk($sformatf("rnd%0d.qn", c),  64'(qn4),  64'(qn_exp));
         chk($sformatf("rnd%0d.inv", c), 64'(inv4), 64'(m_inv));
         chk($sformatf("rnd%0d.any", c), 64'(any4), 64'(|m_inv));
         chk($sformatf("rnd%0d.excl", c), 64'(q4 & qn4), 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_latch_clocked.md
Name: sr_latch_clocked

Overview:
- Clocked, resettable bank of WIDTH independent set/reset storage cells with NOR-latch output semantics.
- Each bit provides a true output and a complementary output.
- The forbidden set+reset combination drives both outputs low and is flagged.
- Used as a synchronous replacement for cross-coupled NOR latches in control/status logic.

Parameters:
WIDTH, 1, number of independent SR cells (bits); legal range 1..64.

Ports:
clk  input  1  rising-edge clock; all state updates occur on this edge.
rst  input  1  asynchronous, active-high reset; forces every cell to the cleared state.
set  input  WIDTH  per-bit set request (S).
reset  input  WIDTH  per-bit clear request (R); this is the latch R input, independent of rst.
q  output  WIDTH  per-bit stored value.
q_not  output  WIDTH  per-bit complementary output.
invalid  output  WIDTH  per-bit flag, high while the cell is in the INVALID state.
invalid_any  output  1  OR-reduction of invalid.

Behaviour:
- Each bit i is a 3-state FSM: CLEAR, SET, INVALID. It is a 2-bit state register per bit; bits never interact.
- Reset:
  - rst high asynchronously forces every bit to CLEAR: q=0, q_not=1, invalid=0, invalid_any=0.
  - Held while rst is high; rst overrides set/reset.
  - Release is synchronous-safe: the first update occurs on the first rising clk after rst falls.
- Transitions, sampled on each rising clk edge with rst low (set[i], reset[i]):
  - 0,0 -> hold the current state (CLEAR, SET or INVALID all persist).
  - 0,1 -> CLEAR.
  - 1,0 -> SET.
  - 1,1 -> INVALID.
- Outputs are a registered decode of state, with no combinational path from set/reset:
  - CLEAR: q=0, q_not=1, invalid=0.
  - SET: q=1, q_not=0, invalid=0.
  - INVALID: q=0, q_not=0, invalid=1.
- Latency: one clock. An input change visible before edge N is reflected in the outputs immediately after edge N.
- Leaving INVALID:
  - 1,1 followed by 0,0 stays INVALID, so outputs remain q=0, q_not=0 (no race resolution).
  - Only a 0,1 or 1,0 request exits INVALID.
- q and q_not are never both 1 in any state, including during reset.
- invalid_any is registered together with the state; it is high iff any bit is INVALID.
- Reset mid-operation: asserting rst between edges clears all bits immediately, regardless of state or pending inputs.
- Inputs are sampled only at clk edges. Glitches between edges have no effect.
- No X propagation from outputs after reset: every output is a defined 0/1 once rst has been asserted.

Test Plan:
- Reset: rst=1 with set=1, reset=0, WIDTH=1 -> q=0, q_not=1, invalid=0 immediately and while held; after release with set=0, reset=0, outputs remain 0/1.
- Clear: set=0, reset=1, one edge -> q=0, q_not=1. Then set=1, reset=0, one edge -> q=1, q_not=0. Then set=0, reset=0 for 3 edges -> q=1, q_not=0 held.
- Forbidden: from SET apply set=1, reset=1, one edge -> q=0, q_not=0, invalid=1, invalid_any=1. Then 0,0 for 2 edges -> still q=0, q_not=0, invalid=1. Then 0,1 -> q=0, q_not=1, invalid=0.
- Latency/async: change set/reset mid-cycle -> outputs unchanged until the next rising clk. Assert rst mid-cycle from SET -> q=0, q_not=1 before the next edge.
- Multi-bit (WIDTH=4): set=4'b0011, reset=4'b0101, one edge -> q=4'b0010, q_not=4'b1100, invalid=4'b0001, invalid_any=1 (bits 2 and 3 retain post-reset CLEAR).
- Invariant check over random stimulus, 1000 cycles: (q & q_not)==0 every cycle; each bit's next state matches the transition table.
